apbif: RTL and testbench
========================

APBIF -- requirements
Module: apbif

Interface
REQ-001 SHALL have port I_PCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port I_PRESET_N, input, 1 bit: reset, synchronous, active-high (value 1 at a rising I_PCLK edge resets the block).
REQ-003 SHALL have port I_PSEL, input, 1 bit: APB slave select.
REQ-004 SHALL have port I_PENABLE, input, 1 bit: APB access-phase enable.
REQ-005 SHALL have port I_PWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-006 SHALL have port I_PADDR, input, 32 bits: byte address.
REQ-007 SHALL have port I_PWDATA, input, 32 bits: write data.
REQ-008 SHALL have port O_PRDATA, output, 32 bits: read data.
REQ-009 SHALL have port O_PREADY, output, 1 bit: transfer-complete indication.
REQ-010 SHALL have no other ports.

Function
REQ-011 SHALL decode word index I_PADDR[4:2]; I_PADDR[1:0] ignored; any address with I_PADDR[31:5] != 0 is unmapped.
REQ-012 SHALL implement this register map (offset, name, access, valid bits):
- 0x00 CTRL, RW: [0] START, [2:1] MODE; bits [31:3] read 0.
- 0x04 SRC_ADDR, RW: [31:0].
- 0x08 DST_ADDR, RW: [31:0].
- 0x0C IMG_WIDTH, RW: [15:0]; [31:16] read 0.
- 0x10 IMG_HEIGHT, RW: [15:0]; [31:16] read 0.
- 0x14 SCRATCH, RW: [31:0].
- 0x18 ID, RO: constant 0x524F5401.
- 0x1C reserved, reads 0.
REQ-013 Write strobe: I_PSEL & I_PENABLE & I_PWRITE sampled at a rising edge.
- The addressed register takes I_PWDATA, masked to its valid bits, at that edge.
REQ-014 Each cycle I_PSEL & I_PENABLE & I_PWRITE stays high SHALL be a separate write, using the I_PADDR/I_PWDATA present in that cycle.
REQ-015 Writes SHALL be ignored when:
- I_PSEL = 0, or
- I_PENABLE = 0 (setup phase), or
- the target is ID, reserved, or unmapped.
REQ-016 O_PREADY SHALL be combinational I_PSEL & I_PENABLE (zero wait states), 0 otherwise.
REQ-017 O_PRDATA SHALL be combinational:
- masked value of the register addressed by I_PADDR when I_PSEL = 1 and I_PWRITE = 0;
- 0 otherwise;
- 0 for reserved/unmapped addresses.
REQ-018 A read in the same cycle as a write to the same register SHALL return the pre-write value; the new value is visible from the next cycle.
REQ-019 Reads SHALL have no side effects.
REQ-020 START SHALL be plain RW storage (no self-clear); MODE SHALL accept all four values 0-3.

Reset
REQ-021 When I_PRESET_N = 1 at a rising edge, all RW registers SHALL become 0.
REQ-022 Reset SHALL override a simultaneous write: the register ends at 0.
REQ-023 Outputs are combinational and SHALL follow the reset register values: every RW register reads 0 after reset; ID reads 0x524F5401.
REQ-024 Reset asserted mid-sequence SHALL discard all prior writes; no pending state remains.

Verification
REQ-025 Reset, then read 0x04 and 0x10 -> O_PRDATA = 0, O_PREADY = 1 in the access phase.
REQ-026 Setup phase (PSEL=1, PENABLE=0, PWRITE=1) with 0x04/128, no access phase -> 0x04 still reads 0.
REQ-027 Write 0x04=128, then 0x08=24, then 0x10=5555, with PENABLE held high throughout -> the registers read 128, 24, 5555 respectively.
REQ-028 Write 0x38=66666 -> ignored; read 0x38 -> 0; all other registers unchanged.
REQ-029 Write 0x0C=0xFFFFFFFF -> reads 0x0000FFFF; write 0x00=0xFFFFFFFF -> reads 0x7; write 0x18=0 -> ID still reads 0x524F5401.
REQ-030 With PSEL=0, write 0x14=0xDEADBEEF -> SCRATCH unchanged; then assert reset during a write to 0x14 -> SCRATCH reads 0.

Source files
------------

// File: rtl/apbif.sv
// APB slave register block: control/geometry registers for an image engine.
// Zero-wait-state, combinational read path, synchronous active-high reset.
module apbif (
   input  logic        I_PCLK,
   input  logic        I_PRESET_N,
   input  logic        I_PSEL,
   input  logic        I_PENABLE,
   input  logic        I_PWRITE,
   input  logic [31:0] I_PADDR,
   input  logic [31:0] I_PWDATA,
   output logic [31:0] O_PRDATA,
   output logic        O_PREADY
);

   localparam logic [31:0] ID_VAL = 32'h524F_5401;

   typedef struct packed {
      logic [2:0]  ctrl;     // [0] START, [2:1] MODE
      logic [31:0] src;
      logic [31:0] dst;
      logic [15:0] width;
      logic [15:0] height;
      logic [31:0] scratch;
   } regs_t;

   regs_t       regs;
   logic        mapped;
   logic [2:0]  idx;
   logic        wr_en;
   logic [31:0] rd_val;
   logic        unused_addr_lsb;

   assign mapped          = (I_PADDR[31:5] == 27'd0);
   assign idx             = I_PADDR[4:2];
   assign wr_en           = I_PSEL & I_PENABLE & I_PWRITE & mapped;
   assign unused_addr_lsb = ^I_PADDR[1:0];

   always_ff @(posedge I_PCLK) begin
      if (I_PRESET_N) begin
         regs <= '0;
      end else if (wr_en) begin
         case (idx)
            3'd0:    regs.ctrl    <= I_PWDATA[2:0];
            3'd1:    regs.src     <= I_PWDATA;
            3'd2:    regs.dst     <= I_PWDATA;
            3'd3:    regs.width   <= I_PWDATA[15:0];
            3'd4:    regs.height  <= I_PWDATA[15:0];
            3'd5:    regs.scratch <= I_PWDATA;
            default: ;  // ID and reserved slots are not writable
         endcase
      end
   end

   always_comb begin
      rd_val = '0;
      case (idx)
         3'd0:    rd_val = {29'd0, regs.ctrl};
         3'd1:    rd_val = regs.src;
         3'd2:    rd_val = regs.dst;
         3'd3:    rd_val = {16'd0, regs.width};
         3'd4:    rd_val = {16'd0, regs.height};
         3'd5:    rd_val = regs.scratch;
         3'd6:    rd_val = ID_VAL;
         default: rd_val = '0;
      endcase
   end

   assign O_PRDATA = (I_PSEL && !I_PWRITE && mapped) ? rd_val : 32'd0;
   assign O_PREADY = I_PSEL & I_PENABLE;

endmodule

// File: tb/tb_apbif.sv
// Scoreboard bench for apbif: reads push expected data, a monitor pops and
// compares on every read access phase; idle/write cycles check PRDATA is 0.
module tb_apbif;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel = 1'b0, pen = 1'b0, pwr = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0;
   logic [31:0] prdata;
   logic        pready;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   localparam logic [31:0] ID_VAL = 32'h524F_5401;

   apbif dut (
      .I_PCLK(clk), .I_PRESET_N(rst), .I_PSEL(psel), .I_PENABLE(pen),
      .I_PWRITE(pwr), .I_PADDR(paddr), .I_PWDATA(pwdata),
      .O_PRDATA(prdata), .O_PREADY(pready)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic s, input logic e, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      psel = s; pen = e; pwr = w; paddr = a; pwdata = d;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      drive(1'b1, 1'b0, 1'b1, a, d);
      drive(1'b1, 1'b1, 1'b1, a, d);
      idle();
   endtask

   task automatic apb_read(input logic [31:0] a, input logic [31:0] exp);
      exp_t e;
      e.addr = a;
      e.data = exp;
      drive(1'b1, 1'b0, 1'b0, a, 32'h0);
      exp_q.push_back(e);
      drive(1'b1, 1'b1, 1'b0, a, 32'h0);
      idle();
   endtask

   // Monitor: sample mid-cycle, away from the rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (psel && pen && !pwr) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL read_unexpected addr=%h got=%h want=<none>", paddr, prdata);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (prdata !== e.data || pready !== 1'b1 || paddr !== e.addr) begin
                  n_err++;
                  $display("FAIL read addr=%h got data=%h ready=%b want data=%h ready=1",
                           e.addr, prdata, pready, e.data);
               end
            end
         end
         if (psel && !pen) begin
            n_chk++;
            if (pready !== 1'b0) begin
               n_err++;
               $display("FAIL setup_ready got=%b want=0", pready);
            end
         end
         if (!psel && pready !== 1'b0) begin
            n_chk++;
            n_err++;
            $display("FAIL idle_ready got=%b want=0", pready);
         end
         if (!(psel && !pwr)) begin
            n_chk++;
            if (prdata !== 32'h0) begin
               n_err++;
               $display("FAIL prdata_zero psel=%b pwrite=%b got=%h want=00000000",
                        psel, pwr, prdata);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset values
      apb_read(32'h04, 32'h0);
      apb_read(32'h10, 32'h0);
      apb_read(32'h00, 32'h0);
      apb_read(32'h18, ID_VAL);

      // setup phase only: no write
      drive(1'b1, 1'b0, 1'b1, 32'h04, 32'd128);
      idle();
      apb_read(32'h04, 32'h0);

      // PENABLE held high: three consecutive writes
      drive(1'b1, 1'b0, 1'b1, 32'h04, 32'd128);
      drive(1'b1, 1'b1, 1'b1, 32'h04, 32'd128);
      drive(1'b1, 1'b1, 1'b1, 32'h08, 32'd24);
      drive(1'b1, 1'b1, 1'b1, 32'h10, 32'd5555);
      idle();
      apb_read(32'h04, 32'd128);
      apb_read(32'h08, 32'd24);
      apb_read(32'h10, 32'd5555);

      // unmapped write/read
      apb_write(32'h38, 32'd66666);
      apb_read(32'h38, 32'h0);
      apb_write(32'h24, 32'd9);           // aliases word 1 but is unmapped
      apb_read(32'h04, 32'd128);
      apb_read(32'h08, 32'd24);
      apb_read(32'h10, 32'd5555);
      apb_read(32'h14, 32'h0);
      apb_read(32'h06, 32'd128);          // byte offset ignored

      // masking, RO, reserved
      apb_write(32'h0C, 32'hFFFF_FFFF);
      apb_read(32'h0C, 32'h0000_FFFF);
      apb_write(32'h00, 32'hFFFF_FFFF);
      apb_read(32'h00, 32'h7);
      apb_read(32'h00, 32'h7);            // START does not self-clear
      apb_write(32'h00, 32'h4);
      apb_read(32'h00, 32'h4);
      apb_write(32'h18, 32'h0);
      apb_read(32'h18, ID_VAL);
      apb_write(32'h1C, 32'h1);
      apb_read(32'h1C, 32'h0);

      // PSEL=0 write ignored
      apb_write(32'h14, 32'hDEAD_BEEF);
      apb_read(32'h14, 32'hDEAD_BEEF);
      drive(1'b0, 1'b1, 1'b1, 32'h14, 32'h1234_5678);
      idle();
      apb_read(32'h14, 32'hDEAD_BEEF);

      // reset during a write to SCRATCH
      drive(1'b1, 1'b0, 1'b1, 32'h14, 32'h5555_AAAA);
      drive(1'b1, 1'b1, 1'b1, 32'h14, 32'h5555_AAAA);
      rst = 1'b1;
      idle();
      rst = 1'b0;
      apb_read(32'h14, 32'h0);
      apb_read(32'h04, 32'h0);
      apb_read(32'h0C, 32'h0);
      apb_read(32'h00, 32'h0);
      apb_read(32'h18, ID_VAL);

      repeat (2) @(posedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
